pwm_capture: RTL
================

Name: pwm_capture

Overview:
Measures an incoming PWM waveform, such as a motor driver feedback line or an RC receiver channel, and reports high time and period in clk cycles. It is the receive-side counterpart of the rover's clk_div PWM generator. Outputs feed the control logic and can be looped back to check generated PWM. It detects a stalled (stuck-high or stuck-low) input.

Parameters:
CNT_W, 16, width of the high_time and period counters and outputs.
TIMEOUT, 40000, clk cycles without any detected edge before the input is declared stuck. Legal range is 2 to 2^CNT_W-1.

Ports:
clk  input  1  system clock, 100 MHz.
reset  input  1  synchronous, active-low reset (reset=0 resets on the clk rising edge).
pwm_in  input  1  asynchronous PWM input.
high_time  output  CNT_W  cycles the input was high in the last complete period.
period  output  CNT_W  cycles between the last two rising edges.
valid  output  1  one-cycle strobe when high_time and period update.
stuck  output  1  level: no edge seen for TIMEOUT cycles.
stuck_level  output  1  synchronized input level when stuck asserted.

Behaviour:
- Reset (reset=0): all outputs 0, synchronizer flops 0, FSM to IDLE, counters 0. Reset mid-measurement discards the partial period.
- Synchronizer: 2 flops plus a 3rd edge-detect flop. rise = s2 & ~s3, fall = ~s2 & s3.
- If pwm_in is already high when reset releases, a rise is detected, because the sync flops reset to 0. This is intended.
- Counter cnt measures cycles since the last detected edge. It is cleared on every rise or fall and otherwise increments. It never exceeds TIMEOUT, so no wrap is possible.
- Register hcnt latches the high duration at fall.
- FSM states:
  - IDLE: waits for rise and ignores fall. On rise, go to HIGH. No valid is produced for this first edge.
  - HIGH: on fall, hcnt <= cnt+1 and go to LOW.
  - LOW: on rise, high_time <= hcnt, period <= hcnt + cnt + 1, valid=1 for exactly 1 cycle, then go to HIGH.
  - Any state except IDLE: if cnt reaches TIMEOUT-1 with no edge, stuck <= 1, stuck_level <= s2, and go to IDLE. high_time and period hold their last values.
- stuck clears on the next detected rise or fall. That edge is treated as in IDLE: only a rise starts a new measurement, and the first full period after recovery produces valid.
- Timing semantics: high_time equals the number of clk cycles pwm_in was sampled high. period equals rise-to-rise distance in clk cycles. Both are exact, with no ±1.
- Latency: valid asserts exactly 4 clk cycles after the first clk edge that samples pwm_in high at the closing rise. This is fixed and independent of values.
- Simultaneous events: rise and fall cannot occur in the same cycle. A timeout cannot coincide with an edge because an edge clears cnt first, so the edge wins.
- Minimum pulse: a 1-cycle high pulse gives high_time=1. Pulses shorter than 1 clk cycle may be missed; this is accepted.
- valid is never asserted while stuck=1.

Decomposition:
- Shared package pwm_pkg:
  - FSM state encoding IDLE/HIGH/LOW, 2 bits.
  - Default CNT_W.
  - PWM_SCALE constant 4000, the constant shared with clk_div.
- One sub-module, sync_edge_det: 2-flop synchronizer plus edge register, with outputs s2, rise and fall. It is reused by future encoder inputs.

Test Plan:
1. pwm_in 30 high / 70 low, 4 periods -> first rise gives no valid; 3 valid strobes 100 cycles apart, each with high_time=30, period=100; valid 4 cycles after each sampled rise.
2. 1 high / 9 low, 3 periods -> high_time=1, period=10; stuck stays 0.
3. TIMEOUT=200: after one valid period, hold pwm_in low -> stuck=1, stuck_level=0 exactly 200 cycles after the detected fall; high_time/period hold. Then 30/70 resumes -> stuck clears at the detected rise, and the next valid comes one full period later with 30/100.
4. TIMEOUT=200: hold pwm_in high after a rise -> stuck=1, stuck_level=1 200 cycles after the detected rise. Then a fall clears stuck and no valid follows until two rises later.
5. Reset pulsed low for 2 cycles mid-HIGH of a 30/70 stream -> all outputs 0 during and after reset; the first valid comes only after two complete post-reset rises, with correct values.
6. TIMEOUT=200: period of 199 (high 50, low 149) -> valid with period=199, no stuck. Period of 250 (low 200) -> stuck asserts and no valid is produced.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM receive path and the rover's clk_div
// PWM generator.
//   pwm_state_t    - measurement FSM encoding (IDLE / HIGH / LOW), 2 bits
//   CNT_W_DEFAULT  - default width of the high-time and period counters
//   PWM_SCALE      - PWM full-scale constant shared with clk_div
package pwm_pkg;

   localparam int CNT_W_DEFAULT = 16;
   localparam int PWM_SCALE     = 4000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } pwm_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: brings an asynchronous level into the clk domain through two
// flops and adds a third flop so that edges of the synchronized level can be
// detected. It is shared by any input that needs clean edge pulses.
// Ports:
//   clk   in   system clock
//   reset in   synchronous, active-low reset (all flops cleared)
//   din   in   asynchronous input level
//   s2    out  synchronized level
//   rise  out  one-cycle pulse on a synchronized 0->1 transition
//   fall  out  one-cycle pulse on a synchronized 1->0 transition
module sync_edge_det
   import pwm_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic s2,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s3;

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform in clk cycles and flags a
// stalled input.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-low reset
//   pwm_in      in   asynchronous PWM input
//   high_time   out  cycles the input was high in the last complete period
//   period      out  cycles between the last two rising edges
//   valid       out  one-cycle strobe when high_time/period update
//   stuck       out  no edge seen for TIMEOUT cycles (level)
//   stuck_level out  synchronized input level captured when stuck asserted
// A closing rise first sampled on edge E produces valid on edge E+4: two
// synchronizer edges, one FSM edge, then two result pipeline stages.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEFAULT,
   parameter int TIMEOUT = 40000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_time,
   output logic [CNT_W-1:0] period,
   output logic             valid,
   output logic             stuck,
   output logic             stuck_level
);

   // cnt parks at TIMEOUT-1; the timeout fires on the edge that would bring
   // it there, so an input quiet for TIMEOUT samples is declared stuck.
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(TIMEOUT - 2);

   logic             s2;
   logic             rise;
   logic             fall;
   pwm_state_t       state;
   pwm_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hcnt;
   logic             timeout_hit;
   logic             close_period;
   logic             vld_p0;
   logic             vld_p1;
   logic [CNT_W-1:0] high_p0;
   logic [CNT_W-1:0] period_p0;
   logic [CNT_W-1:0] high_p1;
   logic [CNT_W-1:0] period_p1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_SAT) ? v : v + 1'b1;
   endfunction

   sync_edge_det u_sync (
      .clk  (clk),
      .reset(reset),
      .din  (pwm_in),
      .s2   (s2),
      .rise (rise),
      .fall (fall)
   );

   // An edge clears cnt first, so a coincident edge always beats the timeout.
   assign timeout_hit  = (state != IDLE) && !rise && !fall && (cnt == CNT_TRIP);
   assign close_period = (state == LOW) && rise;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (rise) state_nxt = HIGH;
         HIGH: begin
            if (fall)             state_nxt = LOW;
            else if (timeout_hit) state_nxt = IDLE;
         end
         LOW: begin
            if (rise)             state_nxt = HIGH;
            else if (timeout_hit) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         hcnt        <= '0;
         stuck       <= 1'b0;
         stuck_level <= 1'b0;
         vld_p0      <= 1'b0;
         high_p0     <= '0;
         period_p0   <= '0;
         vld_p1      <= 1'b0;
         high_p1     <= '0;
         period_p1   <= '0;
         valid       <= 1'b0;
         high_time   <= '0;
         period      <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= (rise || fall) ? '0 : sat_inc(cnt);
         // cnt is one behind the sample count because the clear happens on
         // the edge that detects the transition; +1 makes the result exact.
         if ((state == HIGH) && fall) hcnt <= cnt + 1'b1;
         if (rise || fall) begin
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
         end else if (timeout_hit) begin
            stuck       <= 1'b1;
            stuck_level <= s2;
         end

         // ---- stage p0: result formed at the closing rise
         vld_p0 <= close_period;
         if (close_period) begin
            high_p0   <= hcnt;
            period_p0 <= hcnt + cnt + 1'b1;
         end

         // ---- stage p1 (a timeout, only possible for tiny TIMEOUT, drops the
         // in-flight strobe so valid never overlaps stuck)
         vld_p1    <= vld_p0 && !timeout_hit;
         high_p1   <= high_p0;
         period_p1 <= period_p0;

         // ---- stage p2: registered outputs
         valid <= vld_p1 && !timeout_hit;
         if (vld_p1 && !timeout_hit) begin
            high_time <= high_p1;
            period    <= period_p1;
         end
      end
   end

endmodule
